// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ITER_CNT = 32;
   localparam int unsigned CNT_W    = $clog2(ITER_CNT);
   localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   // Magnitude of x when treated as signed; x unchanged for unsigned ops.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic is_signed);
      return (is_signed && x[XLEN-1]) ? -x : x;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side handshake and HI/LO access for muldiv_ctrl.
interface muldiv_if;
   import muldiv_pkg::*;

   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] in1;
   logic [XLEN-1:0] in2;
   logic            flush;
   logic            wr_hi;
   logic            wr_lo;
   logic [XLEN-1:0] wdata;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, in1, in2, flush, wr_hi, wr_lo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, in1, in2, flush, wr_hi, wr_lo, wdata,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// One iteration on {acc, q}: shift-add multiply, or restoring shift-subtract
// divide when built with MULDIV_DIV_EN.
module muldiv_step
   import muldiv_pkg::*;
(
   input  logic            is_div,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] q,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] acc_nxt,
   output logic [XLEN-1:0] q_nxt
);

   logic [XLEN:0] sum;
`ifdef MULDIV_DIV_EN
   logic [XLEN:0] rem;
`else
   logic unused_is_div;
   assign unused_is_div = is_div;
`endif

   always_comb begin
      sum = {1'b0, acc} + {1'b0, b};
      // Multiplier bits leave q from the bottom while product bits enter from the top.
      if (q[0]) begin
         acc_nxt = sum[XLEN:1];
         q_nxt   = {sum[0], q[XLEN-1:1]};
      end else begin
         acc_nxt = {1'b0, acc[XLEN-1:1]};
         q_nxt   = {acc[0], q[XLEN-1:1]};
      end
`ifdef MULDIV_DIV_EN
      rem = {acc, q[XLEN-1]};
      if (is_div) begin
         if (rem >= {1'b0, b}) begin
            acc_nxt = rem[XLEN-1:0] - b;
            q_nxt   = {q[XLEN-2:0], 1'b1};
         end else begin
            acc_nxt = rem[XLEN-1:0];
            q_nxt   = {q[XLEN-2:0], 1'b0};
         end
      end
`endif
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style HI/LO multiply/divide controller.
// Divide datapath present only when MULDIV_DIV_EN is defined.
//
// state  | meaning
// IDLE   | no operation, HI/LO writable, start accepted
// RUN    | 32 shift-add / shift-subtract iterations on magnitudes
// FIX    | sign correction, HI/LO written at end of cycle
// DONE   | one-cycle result pulse, HI/LO writable, start accepted
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   muldiv_if.slave bus
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   q_q, q_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              is_div_q, is_div_d;
   logic              neg_lo_q, neg_lo_d;
   logic              neg_hi_q, neg_hi_d;
   logic              div0_q, div0_d;

   logic [XLEN-1:0]   step_acc, step_q;
   logic              accept;
   logic              signed_op;
   logic [2*XLEN-1:0] prod;
`ifdef MULDIV_DIV_EN
   logic [XLEN-1:0]   quo, rem;
`else
   logic              unused_div;
   assign unused_div = neg_hi_q ^ div0_q;
`endif

   muldiv_step u_step (
      .is_div  (is_div_q),
      .acc     (acc_q),
      .q       (q_q),
      .b       (b_q),
      .acc_nxt (step_acc),
      .q_nxt   (step_q)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      q_d      = q_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      div0_d   = div0_q;
      prod     = '0;
`ifdef MULDIV_DIV_EN
      quo      = '0;
      rem      = '0;
`endif
      signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start && !bus.flush;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               state_d  = S_RUN;
               cnt_d    = CNT_W'(ITER_CNT - 1);
               acc_d    = '0;
               q_d      = magnitude(bus.in1, signed_op);
               b_d      = magnitude(bus.in2, signed_op);
               is_div_d = bus.op[1];
               neg_lo_d = signed_op && (bus.in1[XLEN-1] ^ bus.in2[XLEN-1]);
               neg_hi_d = bus.op[1] ? (signed_op && bus.in1[XLEN-1])
                                    : (signed_op && (bus.in1[XLEN-1] ^ bus.in2[XLEN-1]));
               div0_d   = bus.op[1] && (bus.in2 == '0);
            end
            if (bus.wr_hi) hi_d = bus.wdata;
            if (bus.wr_lo) lo_d = bus.wdata;
         end
         S_RUN: begin
            acc_d = step_acc;
            q_d   = step_q;
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_FIX: begin
            state_d = S_DONE;
            if (!bus.flush) begin
               if (!is_div_q) begin
                  prod = {acc_q, q_q};
                  if (neg_lo_q) prod = -prod;
                  hi_d = prod[2*XLEN-1:XLEN];
                  lo_d = prod[XLEN-1:0];
               end
`ifdef MULDIV_DIV_EN
               else begin
                  quo  = neg_lo_q ? -q_q : q_q;
                  rem  = neg_hi_q ? -acc_q : acc_q;
                  // A zero divisor leaves the dividend magnitude in acc, so rem is in1.
                  lo_d = div0_q ? DIV0_QUOT : quo;
                  hi_d = rem;
               end
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         q_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         div0_q   <= div0_d;
      end
   end

   assign bus.busy = (state_q == S_RUN) || (state_q == S_FIX);
   assign bus.done = (state_q == S_DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl; division expectations follow MULDIV_DIV_EN.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   muldiv_if bus ();

   muldiv_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] SENT = 32'hC0DE_C0DE;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation, optionally pokes start mid-run, and counts edges to done.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke_at, output logic busy0, output int lat);
      bus.start = 1'b1;
      bus.op    = op;
      bus.in1   = a;
      bus.in2   = b;
      tick();
      bus.start = 1'b0;
      busy0 = bus.busy;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin
         if (lat == poke_at) begin
            bus.start = 1'b1;
            bus.op    = 2'b01;
            bus.in1   = 32'd1;
            bus.in2   = 32'd1;
         end
         tick();
         bus.start = 1'b0;
         lat++;
      end
   endtask

   task automatic preload(input logic [31:0] v);
      bus.wr_hi = 1'b1;
      bus.wr_lo = 1'b1;
      bus.wdata = v;
      tick();
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #22;
      n_checks += 4;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
      if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_multu_max();
      logic b0;
      int   lat;
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, b0, lat);
      n_checks += 4;
      if (b0 !== 1'b1) begin n_fail++; $display("FAIL multu_busy_after_accept: got %b expected 1", b0); end
      if (lat !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d expected 33", lat); end
      if (bus.hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", bus.hi); end
      if (bus.lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", bus.lo); end
      tick();
      n_checks += 2;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b expected 0", bus.done); end
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu_idle_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_mult_signed();
      vec_t v[3];
      logic b0;
      int   lat;
      v[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
      v[1] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      v[2] = '{2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'd30};
      for (int i = 0; i < 3; i++) begin
         run_op(v[i].op, v[i].a, v[i].b, -1, b0, lat);
         n_checks += 3;
         if (lat !== 33) begin n_fail++; $display("FAIL mult_latency[%0d]: got %0d expected 33", i, lat); end
         if (bus.hi !== v[i].hi) begin n_fail++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, bus.hi, v[i].hi); end
         if (bus.lo !== v[i].lo) begin n_fail++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, bus.lo, v[i].lo); end
         tick();
      end
   endtask

   task automatic test_div();
      vec_t        v[6];
      logic        b0;
      int          lat;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      v[0] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
      v[1] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      v[2] = '{2'b11, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF};
      v[3] = '{2'b11, 32'd100,       32'd7,        32'd2,         32'd14};
      v[4] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      v[5] = '{2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
      for (int i = 0; i < 6; i++) begin
         preload(SENT);
`ifdef MULDIV_DIV_EN
         exp_hi = v[i].hi;
         exp_lo = v[i].lo;
`else
         exp_hi = SENT;
         exp_lo = SENT;
`endif
         run_op(v[i].op, v[i].a, v[i].b, -1, b0, lat);
         n_checks += 3;
         if (lat !== 33) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
         if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL div_hi[%0d]: got %h expected %h", i, bus.hi, exp_hi); end
         if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL div_lo[%0d]: got %h expected %h", i, bus.lo, exp_lo); end
         tick();
      end
   endtask

   task automatic test_flush();
      logic b0;
      int   lat;
      preload(SENT);
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.in1   = 32'd1000;
      bus.in2   = 32'd1000;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      n_checks += 3;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
      if (bus.hi !== SENT) begin n_fail++; $display("FAIL flush_hi: got %h expected %h", bus.hi, SENT); end
      if (bus.lo !== SENT) begin n_fail++; $display("FAIL flush_lo: got %h expected %h", bus.lo, SENT); end
      run_op(OP_MULTU, 32'd3, 32'd4, -1, b0, lat);
      n_checks += 3;
      if (lat !== 33) begin n_fail++; $display("FAIL flush_second_latency: got %0d expected 33", lat); end
      if (bus.lo !== 32'd12) begin n_fail++; $display("FAIL flush_second_lo: got %h expected 0000000c", bus.lo); end
      if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL flush_second_hi: got %h expected 0", bus.hi); end
      // Now in DONE: flush and start together must drop the start.
      bus.flush = 1'b1;
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.in1   = 32'd5;
      bus.in2   = 32'd5;
      tick();
      bus.flush = 1'b0;
      bus.start = 1'b0;
      repeat (2) tick();
      n_checks += 2;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_wins_busy: got %b expected 0", bus.busy); end
      if (bus.lo !== 32'd12) begin n_fail++; $display("FAIL flush_wins_lo: got %h expected 0000000c", bus.lo); end
   endtask

   task automatic test_wr_regs();
      logic b0;
      int   lat;
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.in1   = 32'd2;
      bus.in2   = 32'd3;
      tick();
      bus.start = 1'b0;
      bus.wr_hi = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      tick();
      bus.wr_hi = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 40) begin tick(); lat++; end
      n_checks += 2;
      if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL wr_hi_busy_ignored: got %h expected 0", bus.hi); end
      if (bus.lo !== 32'd6) begin n_fail++; $display("FAIL wr_busy_lo: got %h expected 00000006", bus.lo); end
      tick();
      bus.wr_lo = 1'b1;
      bus.wdata = 32'h0000_1234;
      tick();
      bus.wr_lo = 1'b0;
      n_checks += 2;
      if (bus.lo !== 32'h0000_1234) begin n_fail++; $display("FAIL wr_lo_idle: got %h expected 00001234", bus.lo); end
      if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL wr_lo_idle_hi: got %h expected 0", bus.hi); end
      run_op(OP_MULTU, 32'd2, 32'd3, -1, b0, lat);
      bus.wr_hi = 1'b1;
      bus.wdata = 32'h0000_5555;
      tick();
      bus.wr_hi = 1'b0;
      n_checks += 2;
      if (bus.hi !== 32'h0000_5555) begin n_fail++; $display("FAIL wr_hi_done_override: got %h expected 00005555", bus.hi); end
      if (bus.lo !== 32'd6) begin n_fail++; $display("FAIL wr_done_lo: got %h expected 00000006", bus.lo); end
   endtask

   task automatic test_back_to_back();
      logic b0;
      int   lat;
      run_op(OP_MULTU, 32'd7, 32'd8, -1, b0, lat);
      n_checks += 1;
      if (bus.lo !== 32'd56) begin n_fail++; $display("FAIL b2b_first_lo: got %h expected 00000038", bus.lo); end
      run_op(OP_MULTU, 32'd9, 32'd10, 5, b0, lat);
      n_checks += 4;
      if (b0 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_next_edge: got %b expected 1", b0); end
      if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
      if (bus.lo !== 32'd90) begin n_fail++; $display("FAIL b2b_second_lo: got %h expected 0000005a", bus.lo); end
      if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL b2b_second_hi: got %h expected 0", bus.hi); end
      tick();
   endtask

   task automatic test_async_reset();
      int pulses;
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.in1   = 32'hFFFF_FFFF;
      bus.in2   = 32'd2;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      #3;
      reset = 1'b1;
      #1;
      n_checks += 4;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL async_reset_done: got %b expected 0", bus.done); end
      if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL async_reset_hi: got %h expected 0", bus.hi); end
      if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL async_reset_lo: got %h expected 0", bus.lo); end
      @(posedge clk);
      #3;
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done === 1'b1) pulses++;
      end
      n_checks += 2;
      if (pulses !== 0) begin n_fail++; $display("FAIL async_reset_no_done: got %0d pulses expected 0", pulses); end
      if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL async_reset_lo_after: got %h expected 0", bus.lo); end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.in1   = '0;
      bus.in2   = '0;
      bus.flush = 1'b0;
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      bus.wdata = '0;
      test_reset();
      test_multu_max();
      test_mult_signed();
      test_div();
      test_flush();
      test_wr_regs();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
